// File: rtl/ctrl_pkg.sv
// Shared definitions for the serial RX loader and its downstream serializer:
// default geometry, bit-timer width and the receiver state encoding.
package ctrl_pkg;

   localparam int DEF_BIT_PERIOD = 16;
   localparam int DEF_DATA_W     = 16;
   localparam int DEF_ADDR_W     = 8;
   localparam int TMR_W          = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4,
      ST_WRITE  = 3'd5
   } rx_state_e;

endpackage

// File: rtl/serial_rx_loader_if.sv
// RAM write port plus serializer handshake between the loader (master)
// and the RAM/serializer side (slave).
interface serial_rx_loader_if #(
   parameter int DATA_W = ctrl_pkg::DEF_DATA_W,
   parameter int ADDR_W = ctrl_pkg::DEF_ADDR_W
) ();

   logic              write;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] data_in;
   logic              send;
   logic              start_latch;
   logic [ADDR_W:0]   word_count;
   logic              full;

   modport master (
      output write, addr, data_in, start_latch, word_count, full,
      input  send
   );

   modport slave (
      input  write, addr, data_in, start_latch, word_count, full,
      output send
   );

endinterface

// File: rtl/rx_bit_timer.sv
// Loadable bit-period down-counter; expire pulses for one cycle exactly
// load_val cycles after the load cycle. A load in the expiry cycle restarts it.
module rx_bit_timer
   import ctrl_pkg::*;
(
   input  logic             sysclk,
   input  logic             reset,
   input  logic             load,
   input  logic [TMR_W-1:0] load_val,
   output logic             expire
);

   logic [TMR_W-1:0] cnt_q;
   logic [TMR_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - TMR_W'(1);
      end
   end

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire = (cnt_q == TMR_W'(1));

endmodule

// File: rtl/serial_rx_loader.sv
// Serial frame receiver that stores each good word into RAM and hands the
// buffer to the serializer on send. Build macro RX_PARITY_EN adds an even-parity bit.
//
// state  | meaning
// IDLE   | line idle, waiting for a falling edge; services pending send
// START  | half a bit in, confirm start bit is still low
// DATA   | sampling DATA_W bits, LSB first
// PARITY | sampling the even-parity bit (RX_PARITY_EN only)
// STOP   | sampling the stop bit
// WRITE  | one-cycle RAM write strobe, then bump pointer and count
module serial_rx_loader
   import ctrl_pkg::*;
#(
   parameter int BIT_PERIOD = DEF_BIT_PERIOD,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int ADDR_W     = DEF_ADDR_W
)(
   input  logic               sysclk,
   input  logic               reset,
   input  logic               serialIn,
   serial_rx_loader_if.master bus,
   output logic               frame_err,
   output logic               busy
`ifdef RX_PARITY_EN
   ,output logic              parity_err
`endif
);

   localparam logic [TMR_W-1:0]  HALF_T   = TMR_W'(BIT_PERIOD / 2);
   localparam logic [TMR_W-1:0]  PERIOD_T = TMR_W'(BIT_PERIOD);
   localparam int                CNT_W    = ADDR_W + 1;
   localparam logic [CNT_W-1:0]  CNT_FULL = {1'b1, {ADDR_W{1'b0}}};
   localparam int                BC_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [BC_W-1:0]   BC_LAST  = BC_W'(DATA_W - 1);

   rx_state_e         state_q;
   logic              sync1_q, sync2_q, rx_prev_q;
   logic              send_prev_q, send_pend_q;
   logic              write_q, start_latch_q, frame_err_q;
   logic [ADDR_W-1:0] addr_q, ptr_q;
   logic [DATA_W-1:0] data_q, shift_q;
   logic [CNT_W-1:0]  word_count_q;
   logic [BC_W-1:0]   bit_cnt_q;
`ifdef RX_PARITY_EN
   logic              parity_err_q;
`endif

   logic              rx_s, rx_fall, send_rise, svc_req, full_w;
   logic              tmr_load, tmr_exp;
   logic [TMR_W-1:0]  tmr_val;

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         sync1_q   <= serialIn;
         sync2_q   <= sync1_q;
         rx_prev_q <= sync2_q;
      end
   end

   assign rx_s      = sync2_q;
   assign rx_fall   = rx_prev_q & ~sync2_q;
   assign send_rise = bus.send & ~send_prev_q;
   // A readout already in flight clears the count at the end of its pulse.
   assign svc_req   = (send_pend_q | send_rise) & ~start_latch_q;
   assign full_w    = (word_count_q == CNT_FULL);

   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = PERIOD_T;
      if (state_q == ST_IDLE) begin
         tmr_load = rx_fall;
         tmr_val  = HALF_T;
      end else if (state_q == ST_START || state_q == ST_DATA || state_q == ST_PARITY) begin
         tmr_load = tmr_exp;
      end
   end

   rx_bit_timer u_timer (
      .sysclk   (sysclk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .expire   (tmr_exp)
   );

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         send_prev_q   <= 1'b0;
         send_pend_q   <= 1'b0;
         write_q       <= 1'b0;
         start_latch_q <= 1'b0;
         frame_err_q   <= 1'b0;
         addr_q        <= '0;
         ptr_q         <= '0;
         data_q        <= '0;
         shift_q       <= '0;
         word_count_q  <= '0;
         bit_cnt_q     <= '0;
`ifdef RX_PARITY_EN
         parity_err_q  <= 1'b0;
`endif
      end else begin
         write_q       <= 1'b0;
         start_latch_q <= 1'b0;
         send_prev_q   <= bus.send;
         if (send_rise) begin
            send_pend_q <= 1'b1;
         end
         if (start_latch_q) begin
            ptr_q        <= '0;
            word_count_q <= '0;
            frame_err_q  <= 1'b0;
`ifdef RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
         end
         case (state_q)
            ST_IDLE: begin
               if (rx_fall) begin
                  state_q <= ST_START;
               end else if (svc_req) begin
                  send_pend_q   <= 1'b0;
                  start_latch_q <= (word_count_q != '0);
               end
            end
            ST_START: begin
               if (tmr_exp) begin
                  if (rx_s) begin
                     state_q <= ST_IDLE;
                  end else begin
                     state_q   <= ST_DATA;
                     bit_cnt_q <= '0;
                  end
               end
            end
            ST_DATA: begin
               if (tmr_exp) begin
                  shift_q <= {rx_s, shift_q[DATA_W-1:1]};
                  if (bit_cnt_q == BC_LAST) begin
`ifdef RX_PARITY_EN
                     state_q <= ST_PARITY;
`else
                     state_q <= ST_STOP;
`endif
                  end else begin
                     bit_cnt_q <= bit_cnt_q + BC_W'(1);
                  end
               end
            end
`ifdef RX_PARITY_EN
            ST_PARITY: begin
               if (tmr_exp) begin
                  if (rx_s != ^shift_q) begin
                     parity_err_q <= 1'b1;
                     state_q      <= ST_IDLE;
                  end else begin
                     state_q <= ST_STOP;
                  end
               end
            end
`endif
            ST_STOP: begin
               if (tmr_exp) begin
                  if (!rx_s) begin
                     frame_err_q <= 1'b1;
                     state_q     <= ST_IDLE;
                  end else if (full_w) begin
                     state_q <= ST_IDLE;
                  end else begin
                     state_q <= ST_WRITE;
                     write_q <= 1'b1;
                     addr_q  <= ptr_q;
                     data_q  <= shift_q;
                  end
               end
            end
            ST_WRITE: begin
               state_q      <= ST_IDLE;
               word_count_q <= word_count_q + CNT_W'(1);
               // Pointer parks on the last slot once the RAM fills.
               ptr_q        <= (&ptr_q) ? ptr_q : ptr_q + ADDR_W'(1);
               if (svc_req) begin
                  send_pend_q   <= 1'b0;
                  start_latch_q <= 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.write       = write_q;
   assign bus.addr        = addr_q;
   assign bus.data_in     = data_q;
   assign bus.start_latch = start_latch_q;
   assign bus.word_count  = word_count_q;
   assign bus.full        = full_w;
   assign frame_err       = frame_err_q;
   assign busy            = (state_q != ST_IDLE);
`ifdef RX_PARITY_EN
   assign parity_err      = parity_err_q;
`endif

endmodule
